// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types and HD44780 command constants for lcd_text_writer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_CFG   = 3'd2,
        ST_IDLE  = 3'd3,
        ST_ADDR0 = 3'd4,
        ST_ROW0  = 3'd5,
        ST_ADDR1 = 3'd6,
        ST_ROW1  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ACT_START = 2'd0,
        ACT_TX    = 2'd1,
        ACT_GAP   = 2'd2
    } act_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_HIGH  = 2'd2,
        PH_HOLD  = 2'd3
    } phase_t;

    localparam logic [7:0] C_CMD_FUNC  = 8'h28;
    localparam logic [7:0] C_CMD_ENTRY = 8'h06;
    localparam logic [7:0] C_CMD_DISP  = 8'h0C;
    localparam logic [7:0] C_CMD_CLEAR = 8'h01;
    localparam logic [7:0] C_CMD_ADDR0 = 8'h80;
    localparam logic [7:0] C_CMD_ADDR1 = 8'hC0;
    localparam logic [3:0] C_INIT_NIB3 = 4'h3;
    localparam logic [3:0] C_INIT_NIB2 = 4'h2;

    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = C_CMD_FUNC;
            2'd1:    b = C_CMD_ENTRY;
            2'd2:    b = C_CMD_DISP;
            default: b = C_CMD_CLEAR;
        endcase
        return b;
    endfunction

    // Char 0 sits in the top byte, so the bit base is 8 * (31 - idx).
    function automatic logic [7:0] char_at(input logic [255:0] frame, input logic [4:0] idx);
        return frame[{~idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_nibble_tx
// Description : Emits one 4-bit HD44780 strobe: setup, e-high, hold phases.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int EN_CYC = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [3:0] nib,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_d
);

    localparam int C_CNT_W = (EN_CYC > 1) ? $clog2(EN_CYC) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LD = C_CNT_W'(EN_CYC - 1);

    phase_t             phase_q, phase_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               e_q, e_d;
    logic               rs_q, rs_d;
    logic [3:0]         d_q, d_d;

    // A start accepted on the last hold cycle chains straight into the next setup.
    assign done = (phase_q == PH_HOLD) && (cnt_q == '0);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        d_d     = d_q;
        if (phase_q != PH_IDLE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                cnt_d = C_CNT_LD;
                case (phase_q)
                    PH_SETUP: phase_d = PH_HIGH;
                    PH_HIGH:  phase_d = PH_HOLD;
                    default:  phase_d = PH_IDLE;
                endcase
            end
        end
        if (start && (phase_q == PH_IDLE || done)) begin
            phase_d = PH_SETUP;
            cnt_d   = C_CNT_LD;
            rs_d    = rs;
            d_d     = nib;
        end
        e_d = (phase_d == PH_HIGH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            d_q     <= 4'h0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
        end
    end

    assign lcd_e  = e_q;
    assign lcd_rs = rs_q;
    assign lcd_d  = d_q;

endmodule
`default_nettype wire

// File: rtl/lcd_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_text_writer
// Description : Initialises a 16x2 HD44780 in 4-bit mode and redraws 32 chars.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC = 750000,
    parameter int EN_CYC    = 12,
    parameter int CMD_CYC   = 2500,
    parameter int CLR_CYC   = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         refresh,
    input  logic [255:0] text,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [3:0]   lcd_d,
    output logic         busy
);

    localparam int C_GAP_MAX = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int C_GAP_W   = (C_GAP_MAX > 1) ? $clog2(C_GAP_MAX) : 1;
    localparam logic [C_GAP_W-1:0] C_PWRUP_LD = C_GAP_W'(PWRUP_CYC - 1);
    localparam logic [C_GAP_W-1:0] C_CLR_LD   = C_GAP_W'(CLR_CYC - 1);
    localparam logic [C_GAP_W-1:0] C_CMD_LD   = C_GAP_W'(CMD_CYC - 1);

    state_t             state_q, state_d;
    act_t               act_q, act_d;
    logic [C_GAP_W-1:0] gap_q, gap_d;
    logic [4:0]         idx_q, idx_d;
    logic               lo_q, lo_d;
    logic               pend_q, pend_d;
    logic [255:0]       snap_q, snap_d;
    logic               busy_q, busy_d;

    logic               w_start, w_done, w_go, w_last;
    logic               w_is_byte, w_rs;
    logic [7:0]         w_byte;
    logic [3:0]         w_nib;
    logic [C_GAP_W-1:0] w_gap_ld;

    always_comb begin
        w_is_byte = (state_q != ST_INIT);
        w_rs      = (state_q == ST_ROW0) || (state_q == ST_ROW1);
        case (state_q)
            ST_CFG:           w_byte = cfg_byte(idx_q[1:0]);
            ST_ADDR0:         w_byte = C_CMD_ADDR0;
            ST_ADDR1:         w_byte = C_CMD_ADDR1;
            ST_ROW0, ST_ROW1: w_byte = char_at(snap_q, idx_q);
            default:          w_byte = 8'h00;
        endcase
        // The only start issued while a nibble is in flight is the low half of a byte.
        if (!w_is_byte)
            w_nib = (idx_q == 5'd3) ? C_INIT_NIB2 : C_INIT_NIB3;
        else
            w_nib = (act_q == ACT_TX) ? w_byte[3:0] : w_byte[7:4];
        if ((state_q == ST_INIT && idx_q != 5'd3) || (state_q == ST_CFG && idx_q == 5'd3))
            w_gap_ld = C_CLR_LD;
        else
            w_gap_ld = C_CMD_LD;
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        pend_d  = pend_q | (refresh & (state_q != ST_IDLE));
        snap_d  = snap_q;
        w_start = 1'b0;
        w_last  = 1'b0;
        case (act_q)
            ACT_START: begin
                if (state_q == ST_PWRUP) begin
                    gap_d = C_PWRUP_LD;
                    act_d = ACT_GAP;
                end else if (state_q != ST_IDLE) begin
                    w_start = 1'b1;
                    act_d   = ACT_TX;
                end
            end
            ACT_TX: begin
                if (w_done) begin
                    if (w_is_byte && !lo_q) begin
                        w_start = 1'b1;
                        lo_d    = 1'b1;
                    end else begin
                        lo_d  = 1'b0;
                        gap_d = w_gap_ld;
                        act_d = ACT_GAP;
                    end
                end
            end
            ACT_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    act_d = ACT_START;
                    case (state_q)
                        ST_PWRUP: begin
                            state_d = ST_INIT;
                            idx_d   = 5'd0;
                        end
                        ST_INIT: begin
                            if (idx_q == 5'd3) begin
                                state_d = ST_CFG;
                                idx_d   = 5'd0;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end
                        ST_CFG: begin
                            if (idx_q == 5'd3) w_last = 1'b1;
                            else               idx_d  = idx_q + 5'd1;
                        end
                        ST_ADDR0: begin
                            state_d = ST_ROW0;
                            idx_d   = 5'd0;
                        end
                        ST_ROW0: begin
                            if (idx_q == 5'd15) state_d = ST_ADDR1;
                            idx_d = idx_q + 5'd1;
                        end
                        ST_ADDR1: state_d = ST_ROW1;
                        ST_ROW1: begin
                            if (idx_q == 5'd31) w_last = 1'b1;
                            else                idx_d  = idx_q + 5'd1;
                        end
                        default: ;
                    endcase
                end
            end
            default: act_d = ACT_START;
        endcase

        // A pending request at the end of CFG or a frame skips IDLE entirely.
        w_go = (refresh || pend_q) && ((state_q == ST_IDLE) || w_last);
        if (w_go) begin
            state_d = ST_ADDR0;
            act_d   = ACT_START;
            idx_d   = 5'd0;
            pend_d  = 1'b0;
            snap_d  = text;
        end else if (w_last) begin
            state_d = ST_IDLE;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PWRUP;
            act_q   <= ACT_START;
            gap_q   <= '0;
            idx_q   <= 5'd0;
            lo_q    <= 1'b0;
            pend_q  <= 1'b0;
            snap_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            snap_q  <= snap_d;
            busy_q  <= busy_d;
        end
    end

    lcd_nibble_tx #(
        .EN_CYC (EN_CYC)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .rs     (w_rs),
        .nib    (w_nib),
        .done   (w_done),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .lcd_d  (lcd_d)
    );

    assign lcd_rw = 1'b0;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_text_writer
// Description : Scoreboard bench; an LCD bus model decodes strobes on lcd_e fall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_text_writer;

    localparam int PWRUP_CYC = 20;
    localparam int EN_CYC    = 2;
    localparam int CMD_CYC   = 5;
    localparam int CLR_CYC   = 10;
    localparam logic [127:0] ROW_HEX = 128'h30313233343536373839414243444546;
    localparam logic [127:0] ROW_X   = 128'h58585858585858585858585858585858;

    typedef struct packed {
        logic       nib;
        logic       rs;
        logic [7:0] val;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         refresh = 1'b0;
    logic [255:0] text = '0;
    logic         lcd_rs, lcd_rw, lcd_e, busy;
    logic [3:0]   lcd_d;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   strobes = 0;
    int   data_nibs = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    logic prev_e = 1'b0;
    logic hi_valid = 1'b0;
    logic hi_rs = 1'b0;
    logic [3:0] hi_nib = 4'h0;

    lcd_text_writer #(
        .PWRUP_CYC (PWRUP_CYC),
        .EN_CYC    (EN_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLR_CYC   (CLR_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .refresh (refresh),
        .text    (text),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_d   (lcd_d),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic nib, input logic rs, input logic [7:0] v);
        exp_t e;
        e.nib = nib;
        e.rs  = rs;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(1'b1, 1'b0, 8'h03);
        push(1'b1, 1'b0, 8'h03);
        push(1'b1, 1'b0, 8'h03);
        push(1'b1, 1'b0, 8'h02);
        push(1'b0, 1'b0, 8'h28);
        push(1'b0, 1'b0, 8'h06);
        push(1'b0, 1'b0, 8'h0C);
        push(1'b0, 1'b0, 8'h01);
    endtask

    task automatic push_frame(input logic [127:0] r0, input logic [127:0] r1);
        logic [127:0] t;
        push(1'b0, 1'b0, 8'h80);
        t = r0;
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b1, t[127:120]);
            t = t << 8;
        end
        push(1'b0, 1'b0, 8'hC0);
        t = r1;
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b1, t[127:120]);
            t = t << 8;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input int max_cyc, input string name);
        int n;
        n = 0;
        while (busy !== val && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, {31'd0, val});
    endtask

    // Bus model: latch rs/d on each lcd_e fall; strobes during reset are discarded.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hi_valid = 1'b0;
            end else if (prev_e && !lcd_e) begin
                strobes++;
                last_fall_cyc = cyc;
                if (lcd_rs) data_nibs++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL strobe with empty queue: got rs=%0d d=%0h", lcd_rs, lcd_d);
                end else if (exp_q[0].nib) begin
                    mon_e = exp_q.pop_front();
                    check("init nibble {rs,d}", {27'd0, lcd_rs, lcd_d}, {27'd0, mon_e.rs, mon_e.val[3:0]});
                end else if (!hi_valid) begin
                    hi_valid = 1'b1;
                    hi_rs    = lcd_rs;
                    hi_nib   = lcd_d;
                end else begin
                    hi_valid = 1'b0;
                    mon_e = exp_q.pop_front();
                    check("byte {rs_hi,rs_lo,data}", {22'd0, hi_rs, lcd_rs, hi_nib, lcd_d},
                          {22'd0, mon_e.rs, mon_e.rs, mon_e.val});
                end
            end
            prev_e = lcd_e;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int s0, d0, d1, n, idle_cnt, rw_bad;

        // Reset values and the power-up/init/config sequence
        text = {ROW_HEX, ROW_HEX};
        repeat (3) tick();
        check("reset lcd_e", {31'd0, lcd_e}, 32'd0);
        check("reset lcd_rs", {31'd0, lcd_rs}, 32'd0);
        check("reset lcd_d", {28'd0, lcd_d}, 32'd0);
        check("reset lcd_rw", {31'd0, lcd_rw}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd1);
        push_init();
        s0 = strobes;
        rst = 1'b0;
        repeat (5) tick();
        check("busy during power-up", {31'd0, busy}, 32'd1);
        wait_busy(1'b0, 3000, "init completes");
        check("busy fall after final clear gap", cyc - last_fall_cyc, EN_CYC + CLR_CYC);
        check("init strobe count", strobes - s0, 12);
        check("init queue drained", exp_q.size(), 0);

        // One frame from a single-cycle refresh pulse
        push_frame(ROW_HEX, ROW_HEX);
        s0 = strobes;
        pulse_refresh();
        wait_busy(1'b1, 5, "frame starts");
        wait_busy(1'b0, 3000, "frame ends");
        repeat (30) tick();
        check("idle after frame", {31'd0, busy}, 32'd0);
        check("frame strobe count", strobes - s0, 68);
        check("frame queue drained", exp_q.size(), 0);

        // Text changes mid-frame; the snapshot must hold until the next refresh
        push_frame(ROW_HEX, ROW_HEX);
        pulse_refresh();
        repeat (9) tick();
        text = {ROW_X, ROW_X};
        wait_busy(1'b0, 3000, "snapshot frame ends");
        check("snapshot frame drained", exp_q.size(), 0);
        push_frame(ROW_X, ROW_X);
        pulse_refresh();
        wait_busy(1'b0, 3000, "X frame ends");
        check("X frame drained", exp_q.size(), 0);

        // Three requests during one frame collapse into one extra frame
        text = {ROW_HEX, ROW_X};
        push_frame(ROW_HEX, ROW_X);
        push_frame(ROW_HEX, ROW_X);
        s0 = strobes;
        pulse_refresh();
        repeat (50) tick();
        pulse_refresh();
        repeat (100) tick();
        pulse_refresh();
        repeat (100) tick();
        pulse_refresh();
        check("busy while requests collapse", {31'd0, busy}, 32'd1);
        wait_busy(1'b0, 4000, "double frame ends");
        repeat (40) tick();
        check("idle after collapsed requests", {31'd0, busy}, 32'd0);
        check("collapsed strobe count", strobes - s0, 136);
        check("collapsed queue drained", exp_q.size(), 0);

        // Reset while char 7 is strobing
        text = {ROW_HEX, ROW_HEX};
        push(1'b0, 1'b0, 8'h80);
        for (int i = 0; i < 7; i++) push(1'b0, 1'b1, 8'h30 + 8'(i));
        d0 = data_nibs;
        pulse_refresh();
        n = 0;
        while (!((data_nibs - d0 == 14) && lcd_e) && n < 2000) begin
            tick();
            n++;
        end
        check("reached char 7 e-high", {31'd0, lcd_e}, 32'd1);
        rst = 1'b1;
        tick();
        check("lcd_e low after mid-pulse reset", {31'd0, lcd_e}, 32'd0);
        check("busy high in reset", {31'd0, busy}, 32'd1);
        check("chars 0-6 drained before reset", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) tick();
        push_init();
        s0 = strobes;
        d1 = data_nibs;
        rst = 1'b0;
        wait_busy(1'b0, 3000, "re-init completes");
        check("re-init strobe count", strobes - s0, 12);
        check("no data strobes after reset", data_nibs - d1, 0);
        check("re-init queue drained", exp_q.size(), 0);

        // Refresh held high from reset: back-to-back frames, rw never driven
        rst = 1'b1;
        refresh = 1'b1;
        text = {ROW_HEX, ROW_X};
        repeat (3) tick();
        exp_q.delete();
        push_init();
        push_frame(ROW_HEX, ROW_X);
        push_frame(ROW_HEX, ROW_X);
        push_frame(ROW_HEX, ROW_X);
        s0 = strobes;
        idle_cnt = 0;
        rw_bad = 0;
        n = 0;
        rst = 1'b0;
        while (strobes - s0 < 148 && n < 8000) begin
            tick();
            if (!busy) idle_cnt++;
            if (lcd_rw !== 1'b0) rw_bad++;
            n++;
        end
        check("two held-refresh frames reached", strobes - s0, 148);
        refresh = 1'b0;
        while (busy && n < 12000) begin
            tick();
            if (lcd_rw !== 1'b0) rw_bad++;
            n++;
        end
        check("held refresh ends idle", {31'd0, busy}, 32'd0);
        check("idle cycles between held frames", idle_cnt, 0);
        check("lcd_rw stayed low", rw_bad, 0);
        check("held refresh strobe count", strobes - s0, 216);
        check("held refresh queue drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_text_writer.md
LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 750000, power-up wait of 15 ms at 50 MHz.
REQ-002 SHALL have parameter EN_CYC, default 12, lcd_e high time and the setup/hold time around each lcd_e pulse.
REQ-003 SHALL have parameter CMD_CYC, default 2500, gap after each byte other than clear (50 us).
REQ-004 SHALL have parameter CLR_CYC, default 100000, gap after clear and after each 0x3 init nibble (2 ms).
REQ-005 SHALL have ports: clk  in  1  single clock for all logic.
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: refresh  in  1  request to redraw the screen; level or pulse; sampled each clk.
REQ-008 SHALL have ports: text  in  256  32 ASCII chars; char 0 (row 0, col 0) in [255:248]; chars 16-31 are row 1.
REQ-009 SHALL have ports: lcd_rs  out  1 (0 = command, 1 = data); lcd_rw  out  1, tied 0; lcd_e  out  1; lcd_d  out  4, HD44780 4-bit bus.
REQ-010 SHALL have ports: busy  out  1; high from reset release until IDLE is entered with nothing pending.

Function
REQ-011 SHALL run the FSM states PWRUP -> INIT -> CFG -> IDLE -> ADDR0 -> ROW0 -> ADDR1 -> ROW1 -> IDLE.
REQ-012 PWRUP SHALL wait PWRUP_CYC cycles with lcd_e=0.
REQ-013 INIT SHALL send the single nibbles 0x3, 0x3, 0x3, 0x2 with rs=0; each of the first three is followed by CLR_CYC, and 0x2 by CMD_CYC.
REQ-014 CFG SHALL send the bytes 0x28, 0x06, 0x0C, 0x01 (rs=0); 0x01 is followed by CLR_CYC, the others by CMD_CYC.
REQ-015 A byte SHALL be sent as high nibble then low nibble; each nibble is EN_CYC setup (rs and d stable, e=0), EN_CYC e=1, EN_CYC hold (e=0, d held).
REQ-016 Between the two nibbles of a byte there SHALL be no extra gap; the post-byte gap follows the low nibble.
REQ-017 On leaving IDLE, the FSM SHALL snapshot text into an internal 256-bit register; later changes to text SHALL NOT affect the frame in progress.
REQ-018 ADDR0 SHALL send 0x80 (rs=0); ROW0 SHALL send chars 0-15 (rs=1); ADDR1 SHALL send 0xC0; ROW1 SHALL send chars 16-31; each is followed by CMD_CYC.
REQ-019 The char index SHALL be 5 bits, counting 0..31 without wrapping; the ROW0->ADDR1 transition SHALL occur after index 15.
REQ-020 refresh sampled high in any state other than IDLE SHALL set a single pending flag; further requests SHALL collapse into that one flag.
REQ-021 In IDLE, refresh or pending SHALL start a frame on the next clk and clear pending.
REQ-022 refresh held high continuously SHALL produce back-to-back frames.
REQ-023 refresh during PWRUP/INIT/CFG SHALL be honoured once CFG completes.
REQ-024 A full frame SHALL be exactly 34 bytes = 68 nibble strobes.
REQ-025 lcd_e SHALL never be high on two consecutive nibbles without an intervening low of at least 2*EN_CYC cycles.

Reset
REQ-026 While rst=1 at a clk edge: state=PWRUP, all counters=0, pending=0, snapshot=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, busy=1.
REQ-027 rst asserted mid-frame or mid-pulse SHALL force lcd_e=0 on the next edge and restart the full power-up sequence; no partial frame SHALL resume.

Structure
REQ-028 The state encoding and the command constants (0x28, 0x06, 0x0C, 0x01, 0x80, 0xC0) SHALL live in a shared package, lcd_pkg.
REQ-029 A single sub-module, lcd_nibble_tx, SHALL generate one nibble strobe (ports: start, rs, nib, done; timing per REQ-015) and own lcd_e, lcd_rs and lcd_d.
REQ-030 Gap timing SHALL use one down-counter in the parent, sized for max(PWRUP_CYC, CLR_CYC).

Verification (PWRUP_CYC=20, EN_CYC=2, CMD_CYC=5, CLR_CYC=10; an LCD bus model decodes nibbles on the falling edge of lcd_e)
REQ-031 Scenario: reset release -> the model logs nibbles 3,3,3,2 then bytes 28,06,0C,01; busy falls exactly 1 cycle after the final CLR gap.
REQ-032 Scenario: text="0123456789ABCDEF" x2 with a 1-cycle refresh pulse -> the model logs 80, 30..39, 41..46, C0, then the same 16 chars; 68 strobes total; busy=0 afterwards.
REQ-033 Scenario: text changed to all "X" 10 cycles into a frame -> the current frame shows the old text; no "X" appears until the next refresh.
REQ-034 Scenario: 3 refresh pulses during one frame -> exactly one extra frame follows, then IDLE.
REQ-035 Scenario: rst during the e-high phase of char 7 -> lcd_e=0 on the next cycle; the INIT sequence restarts from nibble 3; no data byte is logged before CFG completes.
REQ-036 Scenario: refresh held high from reset -> the first frame starts immediately after CFG; frames repeat with 0 idle cycles between them; lcd_rw stays 0 throughout.
